lif_scheduler: RTL and testbench
================================

// Module: lif_scheduler
// PURPOSE
//  Time-multiplexes one leaky-integrate-and-fire update datapath across NUM_NEURONS neurons.
//  Per-neuron input currents and membrane states live in register arrays.
//  On each timestep tick the block sweeps all neurons in index order.
//  Spikes leave as a valid/ready stream of neuron IDs; the host sees a done pulse when the sweep ends.
//  Sits between the host I/O (current loading, tick) and downstream spike consumers.
// PARAMETERS
//  NUM_NEURONS  8      neurons served; power of two, 2..64
//  WIDTH        8      current/state width in bits
//  THRESH       8'h7F  fire threshold, compared against the next state
//  LEAK_SHIFT   1      leak: state >> LEAK_SHIFT each timestep
//  REFRAC_TS    2      refractory timesteps; used only with LIF_REFRACTORY_EN
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous, active-high reset
//  tick         in   1       start one timestep sweep; sampled in IDLE only
//  cur_wr_en    in   1       write the current register
//  cur_wr_addr  in   IDW     neuron index, IDW = $clog2(NUM_NEURONS)
//  cur_wr_data  in   WIDTH   input current value
//  st_rd_addr   in   IDW     state readback index
//  st_rd_data   out  WIDTH   combinational readback of state[st_rd_addr]
//  spike_valid  out  1       spike ID is presented
//  spike_ready  in   1       consumer accepts the spike
//  spike_id     out  IDW     index of the neuron that fired
//  busy         out  1       high in any state other than IDLE
//  done         out  1       1-cycle pulse when a sweep completes
//  overrun      out  1       sticky; tick arrived while busy; cleared only by rst
// BEHAVIOUR
//  Reset (async, rst=1)
//   - All states and currents 0; FSM goes to IDLE; idx 0.
//   - spike_valid, spike_id, busy, done and overrun are all 0.
//   - Reset mid-sweep aborts the sweep at once; no done pulse follows.
//  FSM states: IDLE, SCAN, EMIT, DONE
//   - IDLE -> SCAN on tick; idx 0.
//   - SCAN: evaluates neuron idx in one cycle.
//     next = cur[idx] + (state[idx] >> LEAK_SHIFT), truncated to WIDTH bits (wraps, no saturation).
//     If next >= THRESH: state[idx] <= 0, spike_id <= idx, go to EMIT.
//     Otherwise: state[idx] <= next; go to SCAN idx+1, or to DONE if idx is the last neuron.
//   - EMIT: spike_valid=1; spike_id is held stable until accepted.
//     On spike_ready the next state is SCAN idx+1, or DONE if idx is the last neuron.
//     spike_valid never drops without a handshake.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//  Latency: with no stalls, a sweep with k spikes runs NUM_NEURONS + k cycles from the tick sample to DONE.
//  Edge cases:
//   - A tick that is not sampled in IDLE is dropped and sets overrun.
//   - A tick in the same cycle as DONE is also dropped.
//   - Current writes are accepted in every FSM state.
//   - Write and SCAN read of the same index in one cycle: SCAN uses the old value; the new value applies next timestep.
//   - cur_wr_addr >= NUM_NEURONS: write ignored.
// CONFIGURATION
//  `LIF_REFRACTORY_EN defined:
//   - Each neuron has a refractory counter, loaded with REFRAC_TS when it fires.
//   - While the counter is nonzero, SCAN holds state at 0, cannot spike, and decrements the counter by 1.
//  Not defined: no counters; a neuron may fire on any timestep.
// STRUCTURE
//  Shared package lif_pkg holds:
//   - FSM state enum lif_sched_state_t
//   - WIDTH/IDW localparams
//   - state typedef lif_state_t
//  Sub-module lif_update_unit: combinational datapath (cur, state, refractory) -> (next, fire).
//  The scheduler holds the register arrays, the FSM and the spike handshake.
// TESTING
//  1. Neuron 0 cur=0x40, others 0; tick 7 times -> state 0x40,60,70,78,7C,7E, then spike_id=0 on tick 7; state 0 afterwards.
//  2. All currents 0x80, spike_ready tied 1 -> 8 spikes with IDs 0..7 in order; done 16 cycles after the tick sample.
//  3. cur[3]=0xFF, spike_ready=0 for 5 cycles -> spike_valid/spike_id=3 held stable; no advance until ready.
//  4. Tick while busy -> overrun=1 and stays 1; the sweep is unaffected; exactly one done pulse.
//  5. Assert rst during EMIT -> all outputs 0 immediately; st_rd_data=0 for every index; the next tick starts a clean sweep.
//  6. With LIF_REFRACTORY_EN: cur[1]=0x80 -> spikes on ticks 1, 4, 7; state reads 0 on the refractory ticks.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF scheduler slice.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package lif_pkg;

    localparam int LIF_NUM_NEURONS = 8;
    localparam int LIF_WIDTH       = 8;
    localparam int LIF_IDW         = $clog2(LIF_NUM_NEURONS);

    typedef logic [LIF_WIDTH-1:0] lif_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } lif_sched_state_t;

    // Bits needed to hold a refractory count of 0..ts (at least one bit).
    function automatic int refrac_cnt_w(input int ts);
        return (ts < 1) ? 1 : $clog2(ts + 1);
    endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Host/consumer-facing bundle of the LIF scheduler: current load, tick, readback, spike stream, status.
// Latency: n/a (wires only).
// Backpressure: spike stream is valid/ready; the slave holds spike_valid/spike_id until spike_ready.
interface lif_scheduler_if
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = LIF_NUM_NEURONS,
    parameter int WIDTH       = LIF_WIDTH
) ();

    localparam int IDW = $clog2(NUM_NEURONS);

    logic             tick;
    logic             cur_wr_en;
    logic [IDW-1:0]   cur_wr_addr;
    logic [WIDTH-1:0] cur_wr_data;
    logic [IDW-1:0]   st_rd_addr;
    logic [WIDTH-1:0] st_rd_data;
    logic             spike_valid;
    logic             spike_ready;
    logic [IDW-1:0]   spike_id;
    logic             busy;
    logic             done;
    logic             overrun;

    // Host and spike consumer side.
    modport master (
        output tick, cur_wr_en, cur_wr_addr, cur_wr_data, st_rd_addr, spike_ready,
        input  st_rd_data, spike_valid, spike_id, busy, done, overrun
    );

    // Scheduler side.
    modport slave (
        input  tick, cur_wr_en, cur_wr_addr, cur_wr_data, st_rd_addr, spike_ready,
        output st_rd_data, spike_valid, spike_id, busy, done, overrun
    );

endinterface

// File: rtl/lif_update_unit.sv
// One-neuron leaky-integrate-and-fire update; optional refractory counter under LIF_REFRACTORY_EN.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the scheduler decides when the result is committed.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int               WIDTH      = LIF_WIDTH,
    parameter logic [WIDTH-1:0] THRESH     = WIDTH'(8'h7F),
    parameter int               LEAK_SHIFT = 1
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int               REFRAC_TS  = 2,
    parameter int               CNT_W      = refrac_cnt_w(REFRAC_TS)
`endif
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] state_i,
`ifdef LIF_REFRACTORY_EN
    input  logic [CNT_W-1:0] refrac_i,
    output logic [CNT_W-1:0] refrac_nxt_o,
`endif
    output logic [WIDTH-1:0] state_nxt_o,
    output logic             fire_o
);

    // Wrapping sum: leaked state plus input current, truncated to WIDTH.
    logic [WIDTH-1:0] sum;
    assign sum = cur_i + (state_i >> LEAK_SHIFT);

    // Fire decision and next membrane state; a firing neuron restarts from zero.
    always_comb begin
        state_nxt_o = sum;
        fire_o      = 1'b0;
`ifdef LIF_REFRACTORY_EN
        refrac_nxt_o = refrac_i;
        if (refrac_i != '0) begin
            state_nxt_o  = '0;
            refrac_nxt_o = refrac_i - 1'b1;
        end else if (sum >= THRESH) begin
            state_nxt_o  = '0;
            fire_o       = 1'b1;
            refrac_nxt_o = CNT_W'(REFRAC_TS);
        end
`else
        if (sum >= THRESH) begin
            state_nxt_o = '0;
            fire_o      = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF sweep over NUM_NEURONS neurons per tick; LIF_REFRACTORY_EN adds refractory counters.
// Latency: NUM_NEURONS + k cycles from tick sample to DONE for k spikes without stalls.
// Backpressure: EMIT holds spike_valid/spike_id until spike_ready; late ticks are dropped and flagged in overrun.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int               NUM_NEURONS = LIF_NUM_NEURONS,
    parameter int               WIDTH       = LIF_WIDTH,
    parameter logic [WIDTH-1:0] THRESH      = WIDTH'(8'h7F),
    parameter int               LEAK_SHIFT  = 1
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int               REFRAC_TS   = 2
`endif
) (
    input  logic          clk,
    input  logic          rst,
    lif_scheduler_if.slave bus
);

    localparam int             IDW      = $clog2(NUM_NEURONS);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_NEURONS - 1);
`ifdef LIF_REFRACTORY_EN
    localparam int             CNT_W    = refrac_cnt_w(REFRAC_TS);
`endif

    lif_sched_state_t fsm_q, fsm_d;
    logic [IDW-1:0]   idx_q, idx_d;
    logic [IDW-1:0]   spike_id_q, spike_id_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] cur_q [NUM_NEURONS];
    logic [WIDTH-1:0] st_q  [NUM_NEURONS];
`ifdef LIF_REFRACTORY_EN
    logic [CNT_W-1:0] refrac_q [NUM_NEURONS];
    logic [CNT_W-1:0] upd_refrac;
`endif

    logic [WIDTH-1:0] upd_state;
    logic             upd_fire;
    logic             cur_wr_ok;
    logic             is_last;

    assign cur_wr_ok = bus.cur_wr_en && (int'(bus.cur_wr_addr) < NUM_NEURONS);
    assign is_last   = (idx_q == LAST_IDX);

    lif_update_unit #(
        .WIDTH      (WIDTH),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
`ifdef LIF_REFRACTORY_EN
        ,
        .REFRAC_TS  (REFRAC_TS),
        .CNT_W      (CNT_W)
`endif
    ) u_update (
        .cur_i        (cur_q[idx_q]),
        .state_i      (st_q[idx_q]),
`ifdef LIF_REFRACTORY_EN
        .refrac_i     (refrac_q[idx_q]),
        .refrac_nxt_o (upd_refrac),
`endif
        .state_nxt_o  (upd_state),
        .fire_o       (upd_fire)
    );

    // Sweep control: scan one neuron per cycle, park in EMIT while a spike waits for the consumer.
    always_comb begin
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        spike_id_d = spike_id_q;
        overrun_d  = overrun_q;
        if (bus.tick && (fsm_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
        unique case (fsm_q)
            ST_IDLE: begin
                if (bus.tick) begin
                    fsm_d = ST_SCAN;
                    idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (upd_fire) begin
                    spike_id_d = idx_q;
                    fsm_d      = ST_EMIT;
                end else if (is_last) begin
                    fsm_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (bus.spike_ready) begin
                    if (is_last) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = ST_SCAN;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            idx_q      <= '0;
            spike_id_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            idx_q      <= idx_d;
            spike_id_q <= spike_id_d;
            overrun_q  <= overrun_d;
        end
    end

    // Neuron storage: host current writes any time; SCAN commits the datapath result for idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cur_q[i] <= '0;
                st_q[i]  <= '0;
`ifdef LIF_REFRACTORY_EN
                refrac_q[i] <= '0;
`endif
            end
        end else begin
            if (cur_wr_ok) begin
                cur_q[bus.cur_wr_addr] <= bus.cur_wr_data;
            end
            if (fsm_q == ST_SCAN) begin
                st_q[idx_q] <= upd_state;
`ifdef LIF_REFRACTORY_EN
                refrac_q[idx_q] <= upd_refrac;
`endif
            end
        end
    end

    assign bus.st_rd_data  = st_q[bus.st_rd_addr];
    assign bus.spike_valid = (fsm_q == ST_EMIT);
    assign bus.spike_id    = spike_id_q;
    assign bus.busy        = (fsm_q != ST_IDLE);
    assign bus.done        = (fsm_q == ST_DONE);
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: leak/fire sequence, full-spike sweep, stall, overrun, reset abort.
// Latency: checks the NUM_NEURONS + k sweep length.
// Backpressure: exercises spike_ready stalls on the spike stream.
module tb_lif_scheduler;
    import lif_pkg::*;

    localparam int N = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [7:0] spk_q [$];

    lif_scheduler_if #(.NUM_NEURONS(N), .WIDTH(8)) bus ();

    lif_scheduler #(
        .NUM_NEURONS (N),
        .WIDTH       (8),
        .THRESH      (8'h7F),
        .LEAK_SHIFT  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wr_cur(input int addr, input logic [7:0] data);
        bus.cur_wr_en   = 1'b1;
        bus.cur_wr_addr = 3'(addr);
        bus.cur_wr_data = data;
        step();
        bus.cur_wr_en   = 1'b0;
    endtask

    task automatic rd_st(input int addr, output logic [7:0] v);
        bus.st_rd_addr = 3'(addr);
        #1;
        v = bus.st_rd_data;
    endtask

    // Tick, collect accepted spike IDs, return cycles from tick sample to done.
    task automatic sweep(output int cyc);
        spk_q.delete();
        cyc = 0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        while (!bus.done && cyc < 300) begin
            if (bus.spike_valid && bus.spike_ready) spk_q.push_back(8'(bus.spike_id));
            step();
            cyc++;
        end
        chk("sweep_done_seen", 32'(bus.done), 1);
        step();
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.spike_valid && k < 50) begin
            step();
            k++;
        end
        chk(tag, 32'(bus.spike_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int         cyc;
        int         cnt;
        logic [7:0] t1_exp [7];

        n_chk = 0;
        n_pass = 0;
        bus.tick = 1'b0;
        bus.cur_wr_en = 1'b0;
        bus.cur_wr_addr = '0;
        bus.cur_wr_data = '0;
        bus.st_rd_addr = '0;
        bus.spike_ready = 1'b1;
        rst = 1'b1;

        // Reset state.
        #12;
        chk("rst_valid", 32'(bus.spike_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_id", 32'(bus.spike_id), 0);
        step();
        rst = 1'b0;

        // Test 1: leak/integrate sequence on neuron 0.
        t1_exp = '{8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h00};
        wr_cur(0, 8'h40);
        for (int t = 0; t < 7; t++) begin
            sweep(cyc);
            rd_st(0, v);
            chk($sformatf("t1_state_tick%0d", t + 1), 32'(v), 32'(t1_exp[t]));
            chk($sformatf("t1_nspk_tick%0d", t + 1), 32'(spk_q.size()), (t == 6) ? 1 : 0);
        end
        chk("t1_spike_id", (spk_q.size() > 0) ? 32'(spk_q[0]) : 32'hFF, 0);

        // Test 2: every neuron fires; sweep length 2*N.
        do_reset();
        for (int i = 0; i < N; i++) wr_cur(i, 8'h80);
        sweep(cyc);
        chk("t2_cycles", 32'(cyc), 16);
        chk("t2_nspk", 32'(spk_q.size()), 8);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t2_id%0d", i), (i < spk_q.size()) ? 32'(spk_q[i]) : 32'hFF, 32'(i));
        end

        // Test 3: consumer stall holds the spike.
        do_reset();
        wr_cur(3, 8'hFF);
        bus.spike_ready = 1'b0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        wait_valid("t3_valid_seen");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_valid%0d", k), 32'(bus.spike_valid), 1);
            chk($sformatf("t3_hold_id%0d", k), 32'(bus.spike_id), 3);
            step();
        end
        bus.spike_ready = 1'b1;
        step();
        chk("t3_valid_after_hs", 32'(bus.spike_valid), 0);
        cnt = 0;
        while (!bus.done && cnt < 50) begin
            step();
            cnt++;
        end
        chk("t3_done_seen", 32'(bus.done), 1);
        step();
        rd_st(3, v);
        chk("t3_state3", 32'(v), 0);

        // Test 4: tick while busy sets sticky overrun; sweep unaffected.
        do_reset();
        wr_cur(2, 8'h80);
        spk_q.delete();
        cnt = 0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 2) bus.tick = 1'b1;
            if (k == 3) bus.tick = 1'b0;
            if (bus.done) cnt++;
            if (bus.spike_valid && bus.spike_ready) spk_q.push_back(8'(bus.spike_id));
            step();
        end
        chk("t4_done_pulses", 32'(cnt), 1);
        chk("t4_nspk", 32'(spk_q.size()), 1);
        chk("t4_id", (spk_q.size() > 0) ? 32'(spk_q[0]) : 32'hFF, 2);
        chk("t4_overrun", 32'(bus.overrun), 1);
        sweep(cyc);
        chk("t4_cycles_next", 32'(cyc), 9);
        chk("t4_overrun_sticky", 32'(bus.overrun), 1);

        // Test 4b: tick in the DONE cycle is dropped.
        do_reset();
        chk("t4b_overrun_pre", 32'(bus.overrun), 0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 50) begin
            step();
            cyc++;
        end
        chk("t4b_cycles", 32'(cyc), 8);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("t4b_overrun", 32'(bus.overrun), 1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.busy) cnt++;
            step();
        end
        chk("t4b_no_sweep", 32'(cnt), 0);

        // Test 5: reset during EMIT aborts cleanly.
        do_reset();
        wr_cur(0, 8'h40);
        wr_cur(3, 8'hFF);
        bus.spike_ready = 1'b0;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        wait_valid("t5_valid_seen");
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("t5_overrun_pre", 32'(bus.overrun), 1);
        rd_st(0, v);
        chk("t5_state0_pre", 32'(v), 8'h40);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(bus.spike_valid), 0);
        chk("t5_id", 32'(bus.spike_id), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_overrun", 32'(bus.overrun), 0);
        for (int i = 0; i < N; i++) begin
            rd_st(i, v);
            chk($sformatf("t5_state%0d", i), 32'(v), 0);
        end
        step();
        rst = 1'b0;
        bus.spike_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done || bus.busy) cnt++;
            step();
        end
        chk("t5_no_done", 32'(cnt), 0);
        wr_cur(3, 8'hFF);
        sweep(cyc);
        chk("t5_clean_cycles", 32'(cyc), 9);
        chk("t5_clean_id", (spk_q.size() == 1) ? 32'(spk_q[0]) : 32'hFF, 3);
        rd_st(0, v);
        chk("t5_state0_post", 32'(v), 0);

`ifdef LIF_REFRACTORY_EN
        // Test 6: refractory period of two timesteps.
        do_reset();
        wr_cur(1, 8'h80);
        for (int t = 1; t <= 7; t++) begin
            sweep(cyc);
            chk($sformatf("t6_nspk_tick%0d", t), 32'(spk_q.size()),
                ((t == 1) || (t == 4) || (t == 7)) ? 1 : 0);
            rd_st(1, v);
            chk($sformatf("t6_state_tick%0d", t), 32'(v), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
